// File: rtl/iob_ram_tdp_be_arb_if.sv
// rtl/iob_ram_tdp_be_arb_if.sv - requester and RAM-port bundle for the shared RAM port arbiter
// The slave view belongs to the arbiter; the master view belongs to the requesters and the RAM.
interface iob_ram_tdp_be_arb_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       req_rdata;
  logic [N_REQ-1:0]        req_rvalid;
  logic                    ram_en;
  logic [STRB_W-1:0]       ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, ram_dout,
    input  req_ready, req_rdata, req_rvalid, ram_en, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, ram_dout,
    output req_ready, req_rdata, req_rvalid, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/iob_ram_tdp_be_arb.sv
// rtl/iob_ram_tdp_be_arb.sv - round-robin arbiter sharing one byte-enable RAM port
// Zero-latency grant, one access per cycle, read data routed back one cycle later.
module iob_ram_tdp_be_arb #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  iob_ram_tdp_be_arb_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grantIdx;
  logic             grantAny;
  logic [N_REQ-1:0] readyVec;
  logic [N_REQ-1:0] rvalidReg;
  int               scanIdx;

  // Scan starts at ptr and wraps modulo N_REQ; reset suppresses every grant
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    scanIdx  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scanIdx = int'(ptr) + i;
      if (scanIdx >= N_REQ) scanIdx = scanIdx - N_REQ;
      if (!grantAny && bus.req_valid[scanIdx]) begin
        grantAny = 1'b1;
        grantIdx = scanIdx[IDX_W-1:0];
      end
    end
    if (rst) grantAny = 1'b0;
  end

  always_comb begin
    readyVec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      readyVec[i] = grantAny && (grantIdx == IDX_W'(i));
    end
  end

  assign bus.req_ready = readyVec;
  assign bus.ram_en    = grantAny;
  assign bus.ram_we    = grantAny ? bus.req_wstrb[grantIdx*STRB_W +: STRB_W] : '0;
  assign bus.ram_addr  = bus.req_addr[grantIdx*ADDR_W +: ADDR_W];
  assign bus.ram_din   = bus.req_wdata[grantIdx*DATA_W +: DATA_W];

  // A return still in flight when reset arrives is dropped, hence the mask
  assign bus.req_rvalid = rst ? '0 : rvalidReg;
  assign bus.req_rdata  = bus.ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rvalidReg <= '0;
    end else begin
      rvalidReg <= readyVec & {N_REQ{~|bus.ram_we}};
      if (grantAny) begin
        ptr <= (grantIdx == IDX_W'(N_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
      end
    end
  end
endmodule
